mux_2_to_1: RTL and testbench

- Two-input, one-select multiplexer. It is the leaf cell used to build wider muxes (e.g. 4:1 from three 2:1 cells) in the datapath.
- Provides a zero-latency combinational output `out` for tree composition.
- Provides a registered copy `out_q` for pipelined use.
- Timescale 1ps/1ps, matching the rest of the mux library.

---
 rtl/mux_pkg.sv | 16 +
 rtl/mux_2_to_1_bit.sv | 34 +++
 rtl/mux_2_to_1.sv | 56 +++++
 tb/tb_mux_2_to_1.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// ============================================================================
//  mux_pkg : shared gate delay and select type for the 2:1 mux library cells
//  Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ps/1ps

package mux_pkg;

  localparam int GATE_DELAY_PS = 50;

  typedef logic sel_t;

endpackage : mux_pkg

`default_nettype wire

// File: rtl/mux_2_to_1_bit.sv
// ============================================================================
//  mux_2_to_1_bit : single-bit structural gate mux, out = (in0&sel_n)|(in1&sel)
//  Optional macro: MUX_2TO1_GATE_DELAY_EN (50 ps per gate primitive)
//  Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ps/1ps

module mux_2_to_1_bit
  import mux_pkg::*;
(
  input  wire logic in0,
  input  wire logic in1,
  input  wire logic sel_n,
  input  wire logic sel,
  output wire logic out
);

  wire logic w_and0;
  wire logic w_and1;

`ifdef MUX_2TO1_GATE_DELAY_EN
  and #(GATE_DELAY_PS) u_and0 (w_and0, in0, sel_n);
  and #(GATE_DELAY_PS) u_and1 (w_and1, in1, sel);
  or  #(GATE_DELAY_PS) u_or   (out, w_and0, w_and1);
`else
  and u_and0 (w_and0, in0, sel_n);
  and u_and1 (w_and1, in1, sel);
  or  u_or   (out, w_and0, w_and1);
`endif

endmodule : mux_2_to_1_bit

`default_nettype wire

// File: rtl/mux_2_to_1.sv
// ============================================================================
//  mux_2_to_1 : WIDTH-bit 2:1 mux, combinational out plus registered out_q
//  Optional macro: MUX_2TO1_GATE_DELAY_EN (gate delay on the shared inverter)
//  Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ps/1ps

module mux_2_to_1
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic [2*WIDTH-1:0] in,
  input  wire logic               sel,
  output wire logic [WIDTH-1:0]   out,
  output logic      [WIDTH-1:0]   out_q
);

  wire sel_t            w_sel_n;
  logic [WIDTH-1:0]     out_q_d;

  // One inverter drives sel_n for every bit slice.
`ifdef MUX_2TO1_GATE_DELAY_EN
  not #(GATE_DELAY_PS) u_inv (w_sel_n, sel);
`else
  not u_inv (w_sel_n, sel);
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux_2_to_1_bit u_bit (
      .in0   (in[i]),
      .in1   (in[WIDTH+i]),
      .sel_n (w_sel_n),
      .sel   (sel),
      .out   (out[i])
    );
  end

  always_comb begin
    out_q_d = out;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_q_d;
    end
  end

endmodule : mux_2_to_1

`default_nettype wire

// File: tb/tb_mux_2_to_1.sv
// ============================================================================
//  tb_mux_2_to_1 : vector tables plus out_q scoreboard for WIDTH=1 and WIDTH=4
//  Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ps/1ps

module tb_mux_2_to_1;

  typedef struct {
    logic [7:0] din;
    logic       s;
    logic [3:0] exp;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [1:0] in1;
  logic       sel1;
  wire  logic [0:0] out1;
  logic [0:0] outq1;
  logic [7:0] in4;
  logic       sel4;
  wire  logic [3:0] out4;
  logic [3:0] outq4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] q1[$];
  logic [3:0] q4[$];

  vec_t v1[11];
  vec_t v4[2];

  mux_2_to_1 #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .in    (in1),
    .sel   (sel1),
    .out   (out1),
    .out_q (outq1)
  );

  mux_2_to_1 #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .in    (in4),
    .sel   (sel4),
    .out   (out4),
    .out_q (outq4)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_mux4(input logic [7:0] d, input logic s);
    return s ? d[7:4] : d[3:0];
  endfunction

  // Drive at the falling edge, check out after a 200 ps settle, queue out_q.
  task automatic apply1(input logic [1:0] d, input logic s, input logic exp);
    @(negedge clk);
    in1  = d;
    sel1 = s;
    q1.push_back({3'b000, exp});
    #200;
    check("out w1", {3'b000, out1}, {3'b000, exp});
  endtask

  task automatic apply4(input logic [7:0] d, input logic s, input logic [3:0] exp);
    @(negedge clk);
    in4  = d;
    sel4 = s;
    q4.push_back(exp);
    #200;
    check("out w4", out4, exp);
  endtask

  always @(posedge clk) begin
    #1;
    if (q1.size() > 0) check("out_q w1 sb", {3'b000, outq1}, q1.pop_front());
    if (q4.size() > 0) check("out_q w4 sb", outq4, q4.pop_front());
  end

  initial begin
    v1[0]  = '{8'h00, 1'b0, 4'h0};
    v1[1]  = '{8'h01, 1'b0, 4'h1};
    v1[2]  = '{8'h01, 1'b1, 4'h0};
    v1[3]  = '{8'h02, 1'b1, 4'h1};
    v1[4]  = '{8'h02, 1'b0, 4'h0};
    v1[5]  = '{8'h03, 1'b0, 4'h1};
    v1[6]  = '{8'h03, 1'b1, 4'h1};
    v1[7]  = '{8'h03, 1'b0, 4'h1};
    v1[8]  = '{8'h00, 1'b0, 4'h0};
    v1[9]  = '{8'h00, 1'b1, 4'h0};
    v1[10] = '{8'h00, 1'b0, 4'h0};
    v4[0]  = '{8'hA5, 1'b0, 4'h5};
    v4[1]  = '{8'hA5, 1'b1, 4'hA};

    reset = 1'b1;
    in1   = 2'b11;
    sel1  = 1'b1;
    in4   = 8'hFF;
    sel4  = 1'b1;

    // Reset clears out_q before any clock edge; out is unaffected.
    #300;
    check("reset out_q w1", {3'b000, outq1}, 4'h0);
    check("reset out_q w4", outq4, 4'h0);
    check("reset out w1", {3'b000, out1}, 4'h1);
    check("reset out w4", out4, 4'hF);
    @(posedge clk); #1;
    check("reset hold out_q w4", outq4, 4'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) apply1(v1[i].din[1:0], v1[i].s, v1[i].exp[0]);
    for (int i = 0; i < 2; i++)  apply4(v4[i].din, v4[i].s, v4[i].exp);
    for (int i = 0; i < 512; i++) begin
      logic [8:0] c;
      c = 9'(i);
      apply4(c[7:0], c[8], ref_mux4(c[7:0], c[8]));
    end

    // Register latency: out_q updates on the edge, not before.
    @(negedge clk);
    in1 = 2'b00; sel1 = 1'b0;
    @(posedge clk); #1;
    check("lat pre out_q", {3'b000, outq1}, 4'h0);
    @(negedge clk);
    in1 = 2'b10; sel1 = 1'b1;
    #200;
    check("lat out", {3'b000, out1}, 4'h1);
    check("lat not before", {3'b000, outq1}, 4'h0);
    @(posedge clk); #1;
    check("lat on edge", {3'b000, outq1}, 4'h1);
    #100;
    in1 = 2'b00;
    #200;
    check("lat out follows", {3'b000, out1}, 4'h0);
    check("lat out_q holds", {3'b000, outq1}, 4'h1);
    @(posedge clk); #1;
    check("lat next edge", {3'b000, outq1}, 4'h0);

    // Asynchronous reset between edges.
    @(negedge clk);
    in1 = 2'b10; sel1 = 1'b1;
    in4 = 8'h3C; sel4 = 1'b0;
    @(posedge clk); #1;
    check("ar pre out_q w1", {3'b000, outq1}, 4'h1);
    check("ar pre out_q w4", outq4, 4'hC);
    #200;
    reset = 1'b1;
    #1;
    check("ar out_q w1", {3'b000, outq1}, 4'h0);
    check("ar out_q w4", outq4, 4'h0);
    check("ar out w1", {3'b000, out1}, 4'h1);
    check("ar out w4", out4, 4'hC);
    @(posedge clk); #1;
    check("ar held w1", {3'b000, outq1}, 4'h0);
    #200;
    reset = 1'b0;
    #1;
    check("ar release no edge", {3'b000, outq1}, 4'h0);
    @(posedge clk); #1;
    check("ar reload w1", {3'b000, outq1}, 4'h1);
    check("ar reload w4", outq4, 4'hC);

    #1000;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mux_2_to_1

`default_nettype wire
